midi_uart_rx: RTL and testbench

MIDI_UART_RX -- requirements
Module: midi_uart_rx

---
 rtl/midi_pkg.sv | 27 ++
 rtl/sync_2ff.sv | 33 +++
 rtl/midi_uart_rx.sv | 163 ++++++++++++++++
 tb/tb_midi_uart_rx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// ============================================================================
// midi_pkg -- shared MIDI receive definitions: FSM encodings, baud constants
// and the 3-input majority helper used for bit sampling.
// Revision: 1.0
// ============================================================================
`default_nettype none

package midi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_BITS  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } midi_state_t;

   localparam int MIDI_BAUD         = 31250;
   localparam int MIDI_CLKS_PER_BIT = 1600;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// sync_2ff -- two-flop synchronizer for one asynchronous bit, resets to 1
// (idle level of a serial line), advances only when enabled.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic i_en,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
      end else if (i_en) begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/midi_uart_rx.sv
// ============================================================================
// midi_uart_rx -- 8N1 MIDI serial receiver with 3-sample majority voting,
// framing-error detection and break hold-off.
// Revision: 1.0
// ============================================================================
`default_nettype none

module midi_uart_rx
   import midi_pkg::*;
#(
   parameter int CLKS_PER_BIT = MIDI_CLKS_PER_BIT
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       CE,
   input  logic       RX,
   output logic [7:0] DATA,
   output logic       DV,
   output logic       FERR,
   output logic       BUSY
);

   localparam int              c_CW     = $clog2(CLKS_PER_BIT);
   localparam logic [c_CW-1:0] c_LAST   = c_CW'(CLKS_PER_BIT - 1);
   localparam logic [c_CW-1:0] c_MID_M1 = c_CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [c_CW-1:0] c_MID    = c_CW'(CLKS_PER_BIT / 2);
   localparam logic [c_CW-1:0] c_MID_P1 = c_CW'(CLKS_PER_BIT / 2 + 1);

   logic            w_rx_s;
   logic            w_vote;
   logic            w_wrap;
   logic [c_CW-1:0] w_cnt_inc;

   midi_state_t     r_state,  w_state_n;
   logic [c_CW-1:0] r_cnt,    w_cnt_n;
   logic [2:0]      r_bit,    w_bit_n;
   logic [7:0]      r_shift,  w_shift_n;
   logic            r_v0,     w_v0_n;
   logic            r_v1,     w_v1_n;
   logic [7:0]      r_data,   w_data_n;
   logic            r_dv,     w_dv_n;
   logic            r_ferr,   w_ferr_n;
   logic            r_rx_d;

   sync_2ff u_sync (
      .clk  (CLK),
      .rst  (RST),
      .i_en (CE),
      .i_d  (RX),
      .o_q  (w_rx_s)
   );

   // Decision is taken at MID+1, combining the two stored samples with the live one
   assign w_vote    = maj3(r_v0, r_v1, w_rx_s);
   assign w_wrap    = (r_cnt == c_LAST);
   assign w_cnt_inc = w_wrap ? '0 : r_cnt + 1'b1;

   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt;
      w_bit_n   = r_bit;
      w_shift_n = r_shift;
      w_v0_n    = r_v0;
      w_v1_n    = r_v1;
      w_data_n  = r_data;
      w_dv_n    = 1'b0;
      w_ferr_n  = 1'b0;

      if (r_state == ST_START || r_state == ST_BITS || r_state == ST_STOP) begin
         if (r_cnt == c_MID_M1) w_v0_n = w_rx_s;
         if (r_cnt == c_MID)    w_v1_n = w_rx_s;
      end

      case (r_state)
         ST_IDLE: begin
            w_cnt_n = '0;
            w_bit_n = '0;
            if (r_rx_d && !w_rx_s) w_state_n = ST_START;
         end
         ST_START: begin
            w_cnt_n = w_cnt_inc;
            if (r_cnt == c_MID_P1 && w_vote) begin
               w_cnt_n   = '0;
               w_state_n = ST_IDLE;
            end else if (w_wrap) begin
               w_state_n = ST_BITS;
            end
         end
         ST_BITS: begin
            w_cnt_n = w_cnt_inc;
            if (r_cnt == c_MID_P1) w_shift_n = {w_vote, r_shift[7:1]};
            if (w_wrap) begin
               if (r_bit == 3'd7) w_state_n = ST_STOP;
               else               w_bit_n   = r_bit + 3'd1;
            end
         end
         ST_STOP: begin
            w_cnt_n = w_cnt_inc;
            // Leaving at mid-stop lets a back-to-back start edge be caught
            if (r_cnt == c_MID_P1) begin
               w_cnt_n = '0;
               if (w_vote) begin
                  w_data_n  = r_shift;
                  w_dv_n    = 1'b1;
                  w_state_n = ST_IDLE;
               end else begin
                  w_ferr_n  = 1'b1;
                  w_state_n = ST_BREAK;
               end
            end
         end
         ST_BREAK: begin
            if (!w_rx_s) begin
               w_cnt_n = '0;
            end else if (w_wrap) begin
               w_cnt_n   = '0;
               w_state_n = ST_IDLE;
            end else begin
               w_cnt_n = r_cnt + 1'b1;
            end
         end
         default: begin
            w_cnt_n   = '0;
            w_state_n = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_v0    <= 1'b1;
         r_v1    <= 1'b1;
         r_data  <= '0;
         r_dv    <= 1'b0;
         r_ferr  <= 1'b0;
         r_rx_d  <= 1'b1;
      end else if (CE) begin
         r_state <= w_state_n;
         r_cnt   <= w_cnt_n;
         r_bit   <= w_bit_n;
         r_shift <= w_shift_n;
         r_v0    <= w_v0_n;
         r_v1    <= w_v1_n;
         r_data  <= w_data_n;
         r_dv    <= w_dv_n;
         r_ferr  <= w_ferr_n;
         r_rx_d  <= w_rx_s;
      end
   end

   // Pulses are held across CE-low cycles but only shown while CE is high
   assign DATA = r_data;
   assign DV   = r_dv & CE;
   assign FERR = r_ferr & CE;
   assign BUSY = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_midi_uart_rx.sv
// ============================================================================
// tb_midi_uart_rx -- directed, table-driven bench for midi_uart_rx at
// CLKS_PER_BIT=16.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_midi_uart_rx;

   localparam int BIT = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ce  = 1'b1;
   logic       rx  = 1'b1;
   logic [7:0] data;
   logic       dv;
   logic       ferr;
   logic       busy;

   int checks = 0;
   int errors = 0;

   int cyc         = 0;
   int dv_cnt      = 0;
   int ferr_cnt    = 0;
   int dv_consec   = 0;
   int pulse_ce_lo = 0;
   int last_dv_cyc = 0;
   logic prev_dv   = 1'b0;
   logic [7:0] dv_q[$];

   logic ce_tog = 1'b0;

   typedef struct {
      logic [7:0] din;
      logic       stop;
      int         dv_exp;
      int         ferr_exp;
      logic [7:0] data_exp;
   } vec_t;

   midi_uart_rx #(.CLKS_PER_BIT(BIT)) dut (
      .CLK  (clk),
      .RST  (rst),
      .CE   (ce),
      .RX   (rx),
      .DATA (data),
      .DV   (dv),
      .FERR (ferr),
      .BUSY (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      if (dv) begin
         dv_cnt      = dv_cnt + 1;
         last_dv_cyc = cyc;
         dv_q.push_back(data);
         if (prev_dv) dv_consec = dv_consec + 1;
      end
      if (ferr) ferr_cnt = ferr_cnt + 1;
      if ((dv || ferr) && !ce) pulse_ce_lo = pulse_ce_lo + 1;
      prev_dv = dv;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         errors = errors + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      if (ce_tog) ce = ~ce;
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      for (int k = 0; k < n; k++) step();
   endtask

   // Drives one frame; leaves rx at the stop level so frames can abut.
   task automatic send_frame(input logic [7:0] b, input logic stop, input int bitlen,
                             input int flip_bit = -1, input int flip_off = 0);
      rx = 1'b0;
      for (int k = 0; k < bitlen; k++) step();
      for (int i = 0; i < 8; i++) begin
         for (int k = 0; k < bitlen; k++) begin
            rx = (i == flip_bit && k == flip_off) ? ~b[i] : b[i];
            step();
         end
      end
      rx = stop;
      for (int k = 0; k < bitlen; k++) step();
   endtask

   initial begin
      vec_t       vecs[6];
      logic [7:0] b2b[3];
      int         dv0, fe0, t0, lat;

      vecs[0] = '{8'hF8, 1'b1, 1, 0, 8'hF8};
      vecs[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
      vecs[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
      vecs[3] = '{8'h55, 1'b1, 1, 0, 8'h55};
      vecs[4] = '{8'h33, 1'b0, 0, 1, 8'h55};
      vecs[5] = '{8'h01, 1'b1, 1, 0, 8'h01};
      b2b[0] = 8'h90; b2b[1] = 8'h3C; b2b[2] = 8'h64;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_data", data, 8'h00);
      check("rst_dv",   dv,   0);
      check("rst_ferr", ferr, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      idle(20);

      // Single byte with latency: stop midpoint is 9.5 bit times (152) plus pipeline
      dv0 = dv_cnt; fe0 = ferr_cnt; t0 = cyc;
      send_frame(8'h90, 1'b1, BIT);
      idle(32);
      check("single_dv",   dv_cnt - dv0, 1);
      check("single_ferr", ferr_cnt - fe0, 0);
      check("single_data", data, 8'h90);
      lat = last_dv_cyc - t0;
      checks = checks + 1;
      if (lat < 154 || lat > 158) begin
         errors = errors + 1;
         $display("FAIL single_latency: got %0d cycles expected 154..158", lat);
      end

      // Table of single frames
      for (int v = 0; v < 6; v++) begin
         dv0 = dv_cnt; fe0 = ferr_cnt;
         send_frame(vecs[v].din, vecs[v].stop, BIT);
         idle(32);
         check($sformatf("vec%0d_dv", v),   dv_cnt - dv0,   vecs[v].dv_exp);
         check($sformatf("vec%0d_ferr", v), ferr_cnt - fe0, vecs[v].ferr_exp);
         check($sformatf("vec%0d_data", v), data,           vecs[v].data_exp);
      end

      // Back-to-back with zero idle time
      dv_q.delete();
      for (int i = 0; i < 3; i++) send_frame(b2b[i], 1'b1, BIT);
      idle(32);
      check("b2b_count", dv_q.size(), 3);
      for (int i = 0; i < 3; i++)
         check($sformatf("b2b_byte%0d", i), (i < dv_q.size()) ? int'(dv_q[i]) : -1, b2b[i]);

      // Framing error followed by a long break
      dv0 = dv_cnt; fe0 = ferr_cnt;
      send_frame(8'h45, 1'b0, BIT);
      for (int k = 0; k < 40 * BIT; k++) step();
      check("brk_ferr", ferr_cnt - fe0, 1);
      check("brk_dv",   dv_cnt - dv0,   0);
      check("brk_data", data, 8'h64);
      check("brk_busy", busy, 1);
      idle(BIT);
      send_frame(8'hC0, 1'b1, BIT);
      idle(32);
      check("brk_next_dv",   dv_cnt - dv0, 1);
      check("brk_next_data", data, 8'hC0);
      check("brk_ferr_once", ferr_cnt - fe0, 1);

      // Short glitch on an idle line
      dv0 = dv_cnt; fe0 = ferr_cnt;
      rx = 1'b0;
      for (int k = 0; k < 4; k++) step();
      check("glitch_busy_hi", busy, 1);
      idle(10);
      check("glitch_busy_lo", busy, 0);
      idle(30);
      check("glitch_dv",   dv_cnt - dv0,   0);
      check("glitch_ferr", ferr_cnt - fe0, 0);

      // One inverted sample at bit-3 midpoint is outvoted
      dv0 = dv_cnt;
      send_frame(8'hAA, 1'b1, BIT, 3, 9);
      idle(32);
      check("vote_dv",   dv_cnt - dv0, 1);
      check("vote_data", data, 8'hAA);

      // Reset during bit 4 of 0x7F, with CE low to show reset priority
      dv0 = dv_cnt; fe0 = ferr_cnt;
      rx = 1'b0;
      for (int k = 0; k < BIT; k++) step();
      rx = 1'b1;
      for (int k = 0; k < 4 * BIT + BIT / 2; k++) step();
      rst = 1'b1; ce = 1'b0;
      repeat (4) @(negedge clk);
      check("mrst_data", data, 8'h00);
      check("mrst_busy", busy, 0);
      check("mrst_dv",   dv,   0);
      check("mrst_ferr", ferr, 0);
      rst = 1'b0; ce = 1'b1;
      idle(48);
      check("mrst_no_dv",   dv_cnt - dv0,   0);
      check("mrst_no_ferr", ferr_cnt - fe0, 0);
      send_frame(8'h12, 1'b1, BIT);
      idle(32);
      check("mrst_next_dv",   dv_cnt - dv0, 1);
      check("mrst_next_data", data, 8'h12);

      // CE at 50% duty: bits are twice as long in clock cycles
      dv0 = dv_cnt; fe0 = ferr_cnt;
      ce_tog = 1'b1;
      send_frame(8'hB0, 1'b1, 2 * BIT);
      idle(64);
      ce_tog = 1'b0; ce = 1'b1;
      idle(16);
      check("ce_dv",      dv_cnt - dv0,   1);
      check("ce_ferr",    ferr_cnt - fe0, 0);
      check("ce_data",    data, 8'hB0);
      check("ce_pulse_lo", pulse_ce_lo, 0);
      check("dv_consecutive", dv_consec, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
